multi_cycle_microprocessor: RTL and testbench

Parametrised multi-cycle successor to the single-cycle MIPS core. One unified external memory port with a req/ready handshake serves both instruction fetch and data access. A 5-phase FSM (fetch/decode/execute/memory/writeback) drives a shared ALU. Variable memory latency is tolerated. Unsupported opcodes trap.

---
 rtl/mcm_pkg.sv | 42 ++++
 rtl/mcm_regfile.sv | 33 +++
 rtl/multi_cycle_microprocessor.sv | 229 ++++++++++++++++++++++
 tb/tb_multi_cycle_microprocessor.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcm_pkg.sv
// Shared ISA encodings, FSM states and ALU operation codes for the multi-cycle core.
package mcm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  function automatic logic funct_legal(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic alu_op_e funct_to_alu(input logic [5:0] fn);
    alu_op_e op;
    case (fn)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mcm_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// Register 0 always reads zero and ignores writes.
module mcm_regfile #(
  parameter int NUM_REGS = 32,
  localparam int IDX_W = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_a_i,
  output logic [31:0]      rdata_a_o,
  input  logic [IDX_W-1:0] raddr_b_i,
  output logic [31:0]      rdata_b_o
);

  logic [31:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? 32'd0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? 32'd0 : regs_q[raddr_b_i];

endmodule

// File: rtl/multi_cycle_microprocessor.sv
// Multi-cycle MIPS-subset core: one req/ready memory port for fetch and data,
// a shared ALU sequenced by a fetch/decode/execute/memory/writeback FSM.
module multi_cycle_microprocessor
  import mcm_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter int              NUM_REGS = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       processor_out,
  output logic              retire,
  output logic              trap
);

  localparam int IDX_W = $clog2(NUM_REGS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       aluout_q, aluout_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [31:0]       pout_q, pout_d;
  logic              retire_q, retire_d;
  logic              trap_q, trap_d;

  logic [5:0]        opcode, funct;
  logic [IDX_W-1:0]  rs_idx, rt_idx, rd_idx;
  logic [31:0]       imm_sext, pc_ext;
  logic [31:0]       rf_a, rf_b;
  logic              rf_we;
  logic [IDX_W-1:0]  rf_waddr;
  logic [31:0]       rf_wdata;

  logic [31:0]       alu_a, alu_b, alu_y;
  alu_op_e           alu_op;

  logic              req_c, we_c;
  logic [ADDR_W-1:0] addr_c;

  assign opcode   = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign rs_idx   = ir_q[21 +: IDX_W];
  assign rt_idx   = ir_q[16 +: IDX_W];
  assign rd_idx   = ir_q[11 +: IDX_W];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc_ext   = 32'(pc_q);

  mcm_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (rs_idx),
    .rdata_a_o (rf_a),
    .raddr_b_i (rt_idx),
    .rdata_b_o (rf_b)
  );

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_y = alu_a + alu_b;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    pout_d   = pout_q;
    retire_d = 1'b0;
    trap_d   = trap_q;
    alu_a    = pc_ext;
    alu_b    = 32'd4;
    alu_op   = ALU_ADD;
    req_c    = 1'b0;
    we_c     = 1'b0;
    addr_c   = pc_q;
    rf_we    = 1'b0;
    rf_waddr = rt_idx;
    rf_wdata = aluout_q;

    case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = alu_y[ADDR_W-1:0];
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d      = rf_a;
        b_d      = rf_b;
        alu_b    = imm_sext << 2;
        aluout_d = alu_y;
        case (opcode)
          OP_RTYPE:              state_d = funct_legal(funct) ? EXEC : TRAP;
          OP_ADDI, OP_LW, OP_SW: state_d = EXEC;
          OP_BEQ:                state_d = BRANCH;
          OP_J:                  state_d = JUMP;
          default:               state_d = TRAP;
        endcase
        if (state_d == TRAP) trap_d = 1'b1;
      end
      EXEC: begin
        alu_a = a_q;
        if (opcode == OP_RTYPE) begin
          alu_b  = b_q;
          alu_op = funct_to_alu(funct);
        end else begin
          alu_b  = imm_sext;
        end
        aluout_d = alu_y;
        case (opcode)
          OP_LW:   state_d = MEM_RD;
          OP_SW:   state_d = MEM_WR;
          default: state_d = WB_ALU;
        endcase
      end
      MEM_RD: begin
        req_c  = 1'b1;
        addr_c = {aluout_q[ADDR_W-1:2], 2'b00};
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = WB_MEM;
        end
      end
      MEM_WR: begin
        req_c  = 1'b1;
        we_c   = 1'b1;
        addr_c = {aluout_q[ADDR_W-1:2], 2'b00};
        if (mem_ready) begin
          retire_d = 1'b1;
          state_d  = FETCH;
        end
      end
      WB_ALU: begin
        rf_we    = 1'b1;
        rf_waddr = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
        pout_d   = aluout_q;
        retire_d = 1'b1;
        state_d  = FETCH;
      end
      WB_MEM: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        pout_d   = mdr_q;
        retire_d = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        // equality test reuses the ALU as a subtractor
        alu_a  = a_q;
        alu_b  = b_q;
        alu_op = ALU_SUB;
        if (alu_y == 32'd0) pc_d = aluout_q[ADDR_W-1:0];
        retire_d = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        pc_d     = ADDR_W'({pc_ext[31:28], ir_q[25:0], 2'b00});
        retire_d = 1'b1;
        state_d  = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = TRAP;
        trap_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      pout_q   <= '0;
      retire_q <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
      pout_q   <= pout_d;
      retire_q <= retire_d;
      trap_q   <= trap_d;
    end
  end

  // reset kills an in-flight request without waiting for the next edge
  assign mem_req       = req_c & ~rst;
  assign mem_we        = we_c & ~rst;
  assign mem_addr      = addr_c;
  assign mem_wdata     = b_q;
  assign processor_out = pout_q;
  assign retire        = retire_q;
  assign trap          = trap_q;

endmodule

// File: tb/tb_multi_cycle_microprocessor.sv
// Bench for multi_cycle_microprocessor: variable-latency memory responder plus an
// instruction-level reference model predicting results, next PC, stores and cycle counts.
module tb_multi_cycle_microprocessor;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ready;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, processor_out;
  logic        retire, trap;

  multi_cycle_microprocessor #(
    .ADDR_W(8), .NUM_REGS(32), .RESET_PC(8'h00)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .processor_out(processor_out), .retire(retire), .trap(trap)
  );

  initial forever #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int lat = 0;
  int wcnt = 0;
  bit hold_data = 1'b0;
  bit abort = 1'b0;

  logic [31:0] dmem  [64];
  logic [31:0] m_mem [64];
  logic [31:0] m_rf  [32];
  logic [7:0]  m_pc;
  logic [31:0] m_pout;
  logic [39:0] wlog [$];

  // memory responder: ready after lat wait cycles; data region can be held off
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && !(hold_data && mem_addr >= 8'h80)) begin
        if (wcnt >= lat) begin
          mem_ready = 1'b1;
          wcnt = 0;
          mem_rdata = dmem[mem_addr[7:2]];
          if (mem_we) begin
            dmem[mem_addr[7:2]] = mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wcnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic load(input int idx, input logic [31:0] w);
    dmem[idx]  = w;
    m_mem[idx] = w;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc   = 8'h00;
    m_pout = '0;
  endtask

  task automatic prep();
    rst = 1'b1;
    lat = 0;
    hold_data = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 64; i++) begin
      dmem[i]  = '0;
      m_mem[i] = '0;
    end
    model_reset();
    wlog.delete();
  endtask

  task automatic start();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wlog.delete();
    @(negedge clk);
  endtask

  // Executes the instruction at m_pc architecturally; returns store info and expected cycles.
  task automatic model_step(output bit st, output logic [7:0] st_addr,
                            output logic [31:0] st_data, output int cycles);
    logic [31:0] ins, a, b, simm, r, ea;
    logic [4:0]  dst;
    logic [7:0]  npc;
    bit          wr;
    ins  = m_mem[m_pc[7:2]];
    a    = m_rf[ins[25:21]];
    b    = m_rf[ins[20:16]];
    simm = {{16{ins[15]}}, ins[15:0]};
    npc  = m_pc + 8'd4;
    wr = 1'b0; st = 1'b0; dst = '0; r = '0; ea = '0;
    st_addr = '0; st_data = '0;
    cycles = 4 + lat;
    case (ins[31:26])
      6'h00: begin
        wr  = 1'b1;
        dst = ins[15:11];
        case (ins[5:0])
          6'h20:   r = a + b;
          6'h22:   r = a - b;
          6'h24:   r = a & b;
          6'h25:   r = a | b;
          6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: r = '0;
        endcase
      end
      6'h08: begin wr = 1'b1; dst = ins[20:16]; r = a + simm; end
      6'h23: begin
        ea = a + simm;
        wr = 1'b1; dst = ins[20:16]; r = m_mem[ea[7:2]];
        cycles = 5 + 2 * lat;
      end
      6'h2B: begin
        ea = a + simm;
        st = 1'b1; st_addr = {ea[7:2], 2'b00}; st_data = b;
        m_mem[ea[7:2]] = b;
        cycles = 4 + 2 * lat;
      end
      6'h04: begin
        if (a == b) npc = npc + 8'(simm << 2);
        cycles = 3 + lat;
      end
      6'h02: begin
        npc = {ins[5:0], 2'b00};
        cycles = 3 + lat;
      end
      default: cycles = 0;
    endcase
    if (wr) begin
      if (dst != 5'd0) m_rf[dst] = r;
      m_pout = r;
    end
    m_pc = npc;
  endtask

  task automatic run_and_compare(input int n, input string tag);
    bit          st;
    logic [7:0]  sa;
    logic [31:0] sd;
    int          ecyc, cyc;
    for (int k = 0; k < n; k++) begin
      if (abort) return;
      model_step(st, sa, sd, ecyc);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (retire !== 1'b1 && cyc < 400);
      vectors++;
      if (retire !== 1'b1) begin
        $display("FAIL %s retire_timeout: no retire in %0d cycles, required after %0d", tag, cyc, ecyc);
        miscompares++;
        abort = 1'b1;
        return;
      end
      vectors++;
      if (cyc != ecyc) begin
        $display("FAIL %s cycles: got %0d, required %0d", tag, cyc, ecyc);
        miscompares++;
      end
      vectors++;
      if (processor_out !== m_pout) begin
        $display("FAIL %s processor_out: got %h, required %h", tag, processor_out, m_pout);
        miscompares++;
      end
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== m_pc) begin
        $display("FAIL %s next_fetch: req=%b addr=%h, required req=1 addr=%h", tag, mem_req, mem_addr, m_pc);
        miscompares++;
      end
      vectors++;
      if (st) begin
        if (wlog.size() != 1 || wlog[0] !== {sa, sd}) begin
          $display("FAIL %s store: %0d writes logged, required one write addr=%h data=%h", tag, wlog.size(), sa, sd);
          miscompares++;
        end
      end else if (wlog.size() != 0) begin
        $display("FAIL %s store: %0d writes logged, required none", tag, wlog.size());
        miscompares++;
      end
      wlog.delete();
      $display("[%s] retire: next_pc=%h out=%h cycles=%0d store=%0b", tag, mem_addr, processor_out, cyc, st);
    end
  endtask

  task automatic test_reset();
    prep();
    load(0, enc_i(6'h08, 5'd1, 5'd0, 16'd3));
    @(negedge clk);
    vectors++;
    if (processor_out !== 32'd0 || retire !== 1'b0 || trap !== 1'b0 ||
        mem_req !== 1'b0 || mem_we !== 1'b0) begin
      $display("FAIL reset_outputs: out=%h retire=%b trap=%b req=%b we=%b, required all 0",
               processor_out, retire, trap, mem_req, mem_we);
      miscompares++;
    end
    start();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00 || mem_we !== 1'b0) begin
      $display("FAIL reset_first_fetch: req=%b addr=%h we=%b, required 1 00 0", mem_req, mem_addr, mem_we);
      miscompares++;
    end
    run_and_compare(1, "reset");
  endtask

  task automatic test_alu_chain();
    prep();
    load(0, enc_i(6'h08, 5'd1, 5'd0, 16'd5));
    load(1, enc_i(6'h08, 5'd2, 5'd0, 16'd7));
    load(2, enc_r(6'h20, 5'd3, 5'd1, 5'd2));
    load(3, enc_r(6'h22, 5'd6, 5'd1, 5'd2));
    load(4, enc_r(6'h24, 5'd7, 5'd1, 5'd2));
    load(5, enc_r(6'h25, 5'd8, 5'd1, 5'd2));
    load(6, enc_r(6'h20, 5'd0, 5'd1, 5'd2));
    load(7, enc_r(6'h20, 5'd9, 5'd0, 5'd3));
    start();
    run_and_compare(8, "alu");
  endtask

  task automatic test_mem_latency();
    prep();
    lat = 3;
    load(0, enc_i(6'h08, 5'd3, 5'd0, 16'd12));
    load(1, enc_j(26'd4));
    load(4, enc_i(6'h2B, 5'd3, 5'd0, 16'd8));
    load(5, enc_i(6'h23, 5'd4, 5'd0, 16'd8));
    load(6, enc_r(6'h20, 5'd5, 5'd4, 5'd0));
    start();
    run_and_compare(5, "mem");
  endtask

  task automatic test_branch();
    prep();
    load(0, enc_i(6'h08, 5'd1, 5'd0, 16'd3));
    load(1, enc_i(6'h08, 5'd2, 5'd0, 16'd4));
    load(2, enc_j(26'd4));
    load(4, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF));
    start();
    run_and_compare(6, "beq_taken");
    prep();
    load(0, enc_i(6'h08, 5'd1, 5'd0, 16'd3));
    load(1, enc_i(6'h08, 5'd2, 5'd0, 16'd4));
    load(2, enc_j(26'd4));
    load(4, enc_i(6'h04, 5'd2, 5'd1, 16'hFFFF));
    start();
    run_and_compare(4, "beq_not_taken");
  endtask

  task automatic test_trap();
    prep();
    load(0, 32'hFC00_0000);
    start();
    @(negedge clk);
    vectors++;
    if (trap !== 1'b0) begin
      $display("FAIL trap_early: got %b during decode, required 0", trap);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (trap !== 1'b1) begin
      $display("FAIL trap_set: got %b, required 1", trap);
      miscompares++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (mem_req !== 1'b0 || retire !== 1'b0 || trap !== 1'b1) begin
        $display("FAIL trap_hold: cycle %0d req=%b retire=%b trap=%b, required 0 0 1", i, mem_req, retire, trap);
        miscompares++;
      end
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (trap !== 1'b0) begin
      $display("FAIL trap_clear: got %b after reset, required 0", trap);
      miscompares++;
    end
    $display("[trap] opcode 3f trapped and cleared by reset");
    prep();
    load(0, enc_r(6'h3F, 5'd1, 5'd0, 5'd0));
    start();
    repeat (2) @(negedge clk);
    vectors++;
    if (trap !== 1'b1 || mem_req !== 1'b0) begin
      $display("FAIL trap_funct: trap=%b req=%b, required 1 0", trap, mem_req);
      miscompares++;
    end
    $display("[trap] funct 3f trap=%b", trap);
  endtask

  task automatic test_reset_mid_lw();
    bit found;
    prep();
    hold_data = 1'b1;
    load(0, enc_i(6'h08, 5'd4, 5'd0, 16'd9));
    load(1, enc_i(6'h23, 5'd4, 5'd0, 16'h0080));
    load(32, 32'hDEAD_BEEF);
    start();
    run_and_compare(1, "rst_lw");
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 8'h80) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      $display("FAIL rst_lw_stall: data read at 80 not seen, required within 20 cycles");
      miscompares++;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || mem_addr !== 8'h00 || processor_out !== 32'd0) begin
      $display("FAIL rst_lw_abort: req=%b addr=%h out=%h, required 0 00 00000000", mem_req, mem_addr, processor_out);
      miscompares++;
    end
    hold_data = 1'b0;
    model_reset();
    start();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
      $display("FAIL rst_lw_restart: req=%b addr=%h, required 1 00", mem_req, mem_addr);
      miscompares++;
    end
    run_and_compare(1, "rst_lw_restart");
  endtask

  task automatic test_wrap_slt();
    prep();
    load(0, enc_i(6'h08, 5'd1, 5'd0, 16'hFFFF));
    load(1, enc_i(6'h08, 5'd2, 5'd0, 16'd1));
    load(2, enc_r(6'h2A, 5'd3, 5'd1, 5'd2));
    load(3, enc_r(6'h2A, 5'd4, 5'd2, 5'd1));
    load(4, enc_j(26'h3F));
    load(63, enc_i(6'h08, 5'd5, 5'd0, 16'd77));
    load(5, enc_r(6'h20, 5'd6, 5'd1, 5'd1));
    start();
    run_and_compare(7, "wrap_slt");
  endtask

  task automatic test_random(input int l);
    int          kind, steps;
    logic [4:0]  rs, rt, rd;
    logic [31:0] w;
    prep();
    lat = l;
    for (int i = 32; i < 64; i++) load(i, $urandom);
    for (int i = 0; i < 28; i++) begin
      kind = $urandom_range(0, 8);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      case (kind)
        0: w = enc_r(6'h20, rd, rs, rt);
        1: w = enc_r(6'h22, rd, rs, rt);
        2: w = enc_r(6'h24, rd, rs, rt);
        3: w = enc_r(6'h25, rd, rs, rt);
        4: w = enc_r(6'h2A, rd, rs, rt);
        5: w = enc_i(6'h08, rt, rs, 16'($urandom));
        6: w = enc_i(6'h23, rt, 5'd0, 16'(128 + $urandom_range(0, 127)));
        7: w = enc_i(6'h2B, rt, 5'd0, 16'(128 + $urandom_range(0, 127)));
        default: w = enc_i(6'h04, rt, ($urandom_range(0, 1) != 0) ? rt : rs,
                           16'($urandom_range(0, 2)));
      endcase
      load(i, w);
    end
    start();
    steps = 0;
    while (m_pc < 8'h70 && steps < 40 && !abort) begin
      run_and_compare(1, "random");
      steps++;
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_alu_chain();
    test_mem_latency();
    test_branch();
    test_trap();
    test_reset_mid_lw();
    test_wrap_slt();
    test_random(0);
    test_random($urandom_range(1, 2));
    test_random($urandom_range(0, 3));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
